// File: rtl/dma_fifo_drain_if.sv
// Memory-bus write channels (address, data, response) between the drain engine and the bus.
interface dma_fifo_drain_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  aw_valid;
    logic                  aw_ready;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_last;
    logic                  b_valid;
    logic                  b_ready;
    logic [1:0]            bresp;

    modport master (
        output aw_valid, aw_addr, aw_len, w_valid, w_data, w_last, b_ready,
        input  aw_ready, w_ready, b_valid, bresp
    );

    modport slave (
        input  aw_valid, aw_addr, aw_len, w_valid, w_data, w_last, b_ready,
        output aw_ready, w_ready, b_valid, bresp
    );
endinterface

// File: rtl/dma_fifo_drain.sv
// Drains the DMA sync FIFO into address/data/response write bursts of up to
// MAX_BURST beats, tracking destination address and remaining word count.
module dma_fifo_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  xfer_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    dma_fifo_drain_if.master      bus
);
    localparam int BYTES = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [LEN_WIDTH-1:0]  remaining_reg;
    logic [8:0]            beats_reg;
    logic [8:0]            popped_reg;
    logic [8:0]            sent_reg;
    logic [1:0]            occ_reg;
    logic                  pend_reg;
    logic                  rd_ptr_reg;
    logic                  wr_ptr_reg;
    logic [DATA_WIDTH-1:0] skid_mem [2];
    logic                  busy_reg;
    logic                  done_reg;
    logic                  err_reg;
    logic                  aw_valid_reg;
    logic [ADDR_WIDTH-1:0] aw_addr_reg;
    logic [7:0]            aw_len_reg;

    logic                  w_valid_next;
    logic                  w_last_next;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic                  w_fire;
    logic                  push;
    logic                  pop_buf;
    logic                  rd_en_next;
    logic [LEN_WIDTH-1:0]  rem_after;
    logic [ADDR_WIDTH-1:0] addr_after;
    logic [8:0]            next_beats;

    function automatic logic [8:0] burst_beats(input logic [LEN_WIDTH-1:0] rem);
        if (rem > LEN_WIDTH'(MAX_BURST))
            return 9'(MAX_BURST);
        return 9'(rem);
    endfunction

    // A word popped last cycle is on fifo_rdata now; with an empty buffer it
    // goes straight to the W channel, otherwise it is parked behind the oldest.
    always_comb begin
        w_valid_next = (state_reg == DATA) && ((occ_reg != 2'd0) || pend_reg);
        w_data_next  = '0;
        if (w_valid_next)
            w_data_next = (occ_reg != 2'd0) ? skid_mem[rd_ptr_reg] : fifo_rdata;
        w_last_next  = w_valid_next && (sent_reg == beats_reg - 9'd1);
        w_fire       = w_valid_next && bus.w_ready;
        pop_buf      = w_fire && (occ_reg != 2'd0);
        push         = pend_reg && !(w_fire && (occ_reg == 2'd0));
        rd_en_next   = (state_reg == DATA) && !fifo_empty && (popped_reg < beats_reg)
                       && (({1'b0, occ_reg} + {2'b00, pend_reg}) < 3'd2);
        rem_after    = remaining_reg - LEN_WIDTH'(beats_reg);
        addr_after   = addr_reg + ADDR_WIDTH'(beats_reg) * ADDR_WIDTH'(BYTES);
        next_beats   = burst_beats(rem_after);
    end

    always_ff @(posedge clk) begin
        if (push)
            skid_mem[wr_ptr_reg] <= fifo_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            beats_reg     <= '0;
            popped_reg    <= '0;
            sent_reg      <= '0;
            occ_reg       <= '0;
            pend_reg      <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            wr_ptr_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            aw_valid_reg  <= 1'b0;
            aw_addr_reg   <= '0;
            aw_len_reg    <= '0;
        end else begin
            pend_reg <= rd_en_next;
            occ_reg  <= occ_reg + {1'b0, push} - {1'b0, pop_buf};
            if (rd_en_next)
                popped_reg <= popped_reg + 9'd1;
            if (w_fire)
                sent_reg <= sent_reg + 9'd1;
            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop_buf)
                rd_ptr_reg <= ~rd_ptr_reg;

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        err_reg  <= 1'b0;
                        busy_reg <= 1'b1;
                        if (xfer_len != '0) begin
                            addr_reg      <= dst_addr;
                            remaining_reg <= xfer_len;
                            beats_reg     <= burst_beats(xfer_len);
                            aw_valid_reg  <= 1'b1;
                            aw_addr_reg   <= dst_addr;
                            aw_len_reg    <= 8'(burst_beats(xfer_len) - 9'd1);
                            state_reg     <= ADDR;
                        end else begin
                            state_reg <= DONE;
                        end
                    end
                end
                ADDR: begin
                    if (bus.aw_ready) begin
                        aw_valid_reg <= 1'b0;
                        popped_reg   <= '0;
                        sent_reg     <= '0;
                        state_reg    <= DATA;
                    end
                end
                DATA: begin
                    if (w_fire && w_last_next)
                        state_reg <= RESP;
                end
                RESP: begin
                    if (bus.b_valid) begin
                        if (bus.bresp != 2'b00)
                            err_reg <= 1'b1;
                        addr_reg      <= addr_after;
                        remaining_reg <= rem_after;
                        if (rem_after != '0) begin
                            beats_reg    <= next_beats;
                            aw_valid_reg <= 1'b1;
                            aw_addr_reg  <= addr_after;
                            aw_len_reg   <= 8'(next_beats - 9'd1);
                            state_reg    <= ADDR;
                        end else begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Zero-length requests arrive here with done still low.
                    if (done_reg) begin
                        done_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        done_reg <= 1'b1;
                        busy_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy         = busy_reg;
    assign done         = done_reg;
    assign err          = err_reg;
    assign fifo_rd_en   = rd_en_next;
    assign bus.aw_valid = aw_valid_reg;
    assign bus.aw_addr  = aw_addr_reg;
    assign bus.aw_len   = aw_len_reg;
    assign bus.w_valid  = w_valid_next;
    assign bus.w_data   = w_data_next;
    assign bus.w_last   = w_last_next;
    assign bus.b_ready  = (state_reg == RESP);
endmodule

// File: tb/tb_dma_fifo_drain.sv
// Directed bench for dma_fifo_drain: FIFO and memory-slave models, a negedge
// monitor that records bus traffic, and per-transfer checks against fixed vectors.
module tb_dma_fifo_drain;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dst_addr = '0;
    logic [15:0] xfer_len = '0;
    logic        busy, done, err;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [31:0] fifo_rdata = '0;

    dma_fifo_drain_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_if();

    dma_fifo_drain #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16), .MAX_BURST(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dst_addr(dst_addr), .xfer_len(xfer_len),
        .busy(busy), .done(done), .err(err), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata), .bus(bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] fq[$];
    logic [31:0] wq[$];
    int          lq[$];
    logic [31:0] awa_q[$];
    logic [7:0]  awl_q[$];

    int pops, empty_pops, stab_err, done_cnt, done_cyc, b_cnt, last_b_cyc, aw_cyc;
    int first_pop_cyc, first_wv_cyc, first_w_cyc, last_w_cyc, busy_at_done, err_at_done;
    int err_burst = -1;
    int b_idx = 0;
    int starve_at = -1;
    int starve_left = 0;
    bit rand_ready = 1'b0;
    bit b_pend = 1'b0;
    bit ms_pop, ms_bhs, ms_wl;
    bit stall_w = 1'b0;
    bit stall_aw = 1'b0;
    logic [31:0] prev_wd, prev_aa;
    logic        prev_wl;
    logic [7:0]  prev_al;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wd_at(input int i);
        if (i < wq.size()) return wq[i];
        return 32'hFFFF_FFFF;
    endfunction
    function automatic int wl_at(input int i);
        if (i < lq.size()) return lq[i];
        return -1;
    endfunction
    function automatic logic [31:0] aa_at(input int i);
        if (i < awa_q.size()) return awa_q[i];
        return 32'hFFFF_FFFF;
    endfunction
    function automatic logic [7:0] al_at(input int i);
        if (i < awl_q.size()) return awl_q[i];
        return 8'hFF;
    endfunction

    task automatic clear_obs();
        wq.delete(); lq.delete(); awa_q.delete(); awl_q.delete();
        pops = 0; empty_pops = 0; stab_err = 0; done_cnt = 0; done_cyc = -1; b_cnt = 0;
        last_b_cyc = -1; aw_cyc = -1; first_pop_cyc = -1; first_wv_cyc = -1;
        first_w_cyc = -1; last_w_cyc = -1; busy_at_done = -1; err_at_done = -1; b_idx = 0;
    endtask

    task automatic do_start(input logic [31:0] a, input logic [15:0] l);
        dst_addr = a;
        xfer_len = l;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        $display("start addr=0x%0h len=%0d", a, l);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
        check_val({tag, "_done_seen"}, done_cnt != 0, 1);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    // Monitor samples mid-cycle; the FIFO/slave models update just after the edge.
    initial begin
        bus_if.aw_ready = 1'b1;
        bus_if.w_ready  = 1'b1;
        bus_if.b_valid  = 1'b0;
        bus_if.bresp    = 2'b00;
        clear_obs();
        forever begin
            @(negedge clk);
            cyc++;
            ms_pop = 1'b0; ms_bhs = 1'b0; ms_wl = 1'b0;
            if (rst_n) begin
                if (stall_w && (!bus_if.w_valid || bus_if.w_data != prev_wd || bus_if.w_last != prev_wl))
                    stab_err++;
                if (stall_aw && (!bus_if.aw_valid || bus_if.aw_addr != prev_aa || bus_if.aw_len != prev_al))
                    stab_err++;
                stall_w  = bus_if.w_valid && !bus_if.w_ready;
                stall_aw = bus_if.aw_valid && !bus_if.aw_ready;
                prev_wd = bus_if.w_data; prev_wl = bus_if.w_last;
                prev_aa = bus_if.aw_addr; prev_al = bus_if.aw_len;
                if (fifo_rd_en) begin
                    pops++;
                    ms_pop = 1'b1;
                    if (fifo_empty) empty_pops++;
                    if (first_pop_cyc < 0) first_pop_cyc = cyc;
                end
                if (bus_if.w_valid && first_wv_cyc < 0) first_wv_cyc = cyc;
                if (bus_if.aw_valid && bus_if.aw_ready) begin
                    awa_q.push_back(bus_if.aw_addr);
                    awl_q.push_back(bus_if.aw_len);
                    aw_cyc = cyc;
                    $display("aw  addr=0x%0h len=%0d", bus_if.aw_addr, bus_if.aw_len);
                end
                if (bus_if.w_valid && bus_if.w_ready) begin
                    wq.push_back(bus_if.w_data);
                    lq.push_back(int'(bus_if.w_last));
                    if (first_w_cyc < 0) first_w_cyc = cyc;
                    last_w_cyc = cyc;
                    ms_wl = bus_if.w_last;
                end
                if (bus_if.b_valid && bus_if.b_ready) begin
                    b_cnt++;
                    last_b_cyc = cyc;
                    ms_bhs = 1'b1;
                    $display("b   resp=%0d", bus_if.bresp);
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    busy_at_done = int'(busy);
                    err_at_done = int'(err);
                end
            end else begin
                stall_w  = 1'b0;
                stall_aw = 1'b0;
            end
            @(posedge clk); #1;
            if (!rst_n) begin
                bus_if.b_valid = 1'b0;
                b_pend = 1'b0;
            end else begin
                if (ms_pop) fifo_rdata = (fq.size() > 0) ? fq.pop_front() : 32'hDEAD_BEEF;
                if (ms_bhs) bus_if.b_valid = 1'b0;
                if (ms_wl) b_pend = 1'b1;
                if (b_pend && !bus_if.b_valid) begin
                    bus_if.b_valid = 1'b1;
                    bus_if.bresp   = (b_idx == err_burst) ? 2'd2 : 2'd0;
                    b_idx++;
                    b_pend = 1'b0;
                end
            end
            if (starve_left > 0) starve_left--;
            if (starve_at >= 0 && pops == starve_at) begin
                starve_left = 5;
                starve_at = -1;
            end
            fifo_empty = (fq.size() == 0) || (starve_left > 0);
            bus_if.aw_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus_if.w_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_ctrl_outputs",
                  {busy, done, err, bus_if.aw_valid, bus_if.w_valid, bus_if.w_last, fifo_rd_en, bus_if.b_ready}, 0);
        check_val("reset_aw_addr", bus_if.aw_addr, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single burst of 4
        clear_obs();
        for (int i = 0; i < 4; i++) fq.push_back(32'hA + i);
        do_start(32'h1000, 16'd4);
        @(negedge clk);
        check_val("t1_busy_after_start", busy, 1);
        check_val("t1_aw_valid_after_start", bus_if.aw_valid, 1);
        wait_done("t1", 100);
        check_val("t1_aw_count", awa_q.size(), 1);
        check_val("t1_aw_addr", aa_at(0), 32'h1000);
        check_val("t1_aw_len", al_at(0), 3);
        check_val("t1_beats", wq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("t1_data%0d", i), wd_at(i), 32'hA + i);
            check_val($sformatf("t1_last%0d", i), wl_at(i), (i == 3));
        end
        check_val("t1_pop_after_aw", first_pop_cyc - aw_cyc, 1);
        check_val("t1_wvalid_after_pop", first_wv_cyc - first_pop_cyc, 1);
        check_val("t1_one_beat_per_cycle", last_w_cyc - first_w_cyc, 3);
        check_val("t1_done_after_b", done_cyc - last_b_cyc, 1);
        check_val("t1_busy_at_done", busy_at_done, 0);
        check_val("t1_pops", pops, 4);
        check_val("t1_err", err, 0);

        // Three bursts, with a start pulse mid-transfer that must be ignored
        clear_obs();
        for (int i = 0; i < 40; i++) fq.push_back(32'h100 + i);
        do_start(32'h2000, 16'd40);
        repeat (10) begin @(posedge clk); #1; end
        dst_addr = 32'h9000; xfer_len = 16'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t2", 400);
        repeat (5) begin @(posedge clk); #1; end
        check_val("t2_aw_count", awa_q.size(), 3);
        check_val("t2_aw0_addr", aa_at(0), 32'h2000);
        check_val("t2_aw0_len", al_at(0), 15);
        check_val("t2_aw1_addr", aa_at(1), 32'h2040);
        check_val("t2_aw1_len", al_at(1), 15);
        check_val("t2_aw2_addr", aa_at(2), 32'h2080);
        check_val("t2_aw2_len", al_at(2), 7);
        check_val("t2_pops", pops, 40);
        check_val("t2_beats", wq.size(), 40);
        for (int i = 0; i < 40; i++) begin
            check_val($sformatf("t2_data%0d", i), wd_at(i), 32'h100 + i);
            check_val($sformatf("t2_last%0d", i), wl_at(i), (i == 15 || i == 31 || i == 39));
        end
        check_val("t2_done_count", done_cnt, 1);

        // Random ready on AW/W plus a 5-cycle FIFO starve after the 5th pop
        clear_obs();
        for (int i = 0; i < 12; i++) fq.push_back(32'h300 + i);
        rand_ready = 1'b1;
        starve_at = 5;
        do_start(32'h3000, 16'd12);
        wait_done("t3", 1000);
        rand_ready = 1'b0;
        check_val("t3_aw_addr", aa_at(0), 32'h3000);
        check_val("t3_aw_len", al_at(0), 11);
        check_val("t3_beats", wq.size(), 12);
        for (int i = 0; i < 12; i++)
            check_val($sformatf("t3_data%0d", i), wd_at(i), 32'h300 + i);
        check_val("t3_pops", pops, 12);
        check_val("t3_pop_while_empty", empty_pops, 0);
        check_val("t3_hold_stability", stab_err, 0);

        // Error on the first of two bursts
        clear_obs();
        err_burst = 0;
        for (int i = 0; i < 20; i++) fq.push_back(32'h400 + i);
        do_start(32'h4000, 16'd20);
        wait_done("t4", 400);
        err_burst = -1;
        check_val("t4_err_at_done", err_at_done, 1);
        check_val("t4_err_sticky", err, 1);
        check_val("t4_aw_count", awa_q.size(), 2);
        check_val("t4_aw1_addr", aa_at(1), 32'h4040);
        check_val("t4_aw1_len", al_at(1), 3);
        check_val("t4_b_count", b_cnt, 2);
        check_val("t4_beats", wq.size(), 20);

        // Zero length: clears err, done two cycles after start, no bus traffic
        clear_obs();
        do_start(32'h5000, 16'd0);
        @(negedge clk);
        check_val("t5_err_cleared", err, 0);
        check_val("t5_busy_n1", busy, 1);
        check_val("t5_done_n1", done, 0);
        @(negedge clk);
        check_val("t5_done_n2", done, 1);
        check_val("t5_busy_n2", busy, 0);
        @(negedge clk);
        check_val("t5_done_n3", done, 0);
        repeat (4) begin @(posedge clk); #1; end
        check_val("t5_aw_count", awa_q.size(), 0);
        check_val("t5_pops", pops, 0);
        check_val("t5_done_count", done_cnt, 1);

        // Reset after beat 3 of 8
        clear_obs();
        for (int i = 0; i < 8; i++) fq.push_back(32'h600 + i);
        do_start(32'h6000, 16'd8);
        begin
            int n = 0;
            do begin
                @(negedge clk); #2;
                n++;
            end while (wq.size() < 3 && n < 100);
        end
        check_val("t6_reached_beat3", wq.size(), 3);
        rst_n = 1'b0;
        #1;
        check_val("t6_async_ctrl_zero",
                  {busy, done, err, bus_if.aw_valid, bus_if.w_valid, bus_if.w_last, fifo_rd_en, bus_if.b_ready}, 0);
        check_val("t6_async_wdata_zero", bus_if.w_data, 0);
        repeat (3) @(posedge clk);
        #1;
        fq.delete();
        rst_n = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        check_val("t6_no_done", done_cnt, 0);

        // Normal transfer after the aborted one
        clear_obs();
        for (int i = 0; i < 4; i++) fq.push_back(32'h70 + i);
        repeat (2) begin @(posedge clk); #1; end
        do_start(32'h7000, 16'd4);
        wait_done("t7", 100);
        check_val("t7_aw_addr", aa_at(0), 32'h7000);
        check_val("t7_aw_len", al_at(0), 3);
        check_val("t7_beats", wq.size(), 4);
        for (int i = 0; i < 4; i++)
            check_val($sformatf("t7_data%0d", i), wd_at(i), 32'h70 + i);
        check_val("t7_done_count", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
